// File: rtl/mire_gen.sv
// mire_gen: test-pattern pixel source feeding the VGA output stage.
// Emits a raster-ordered RGB888 stream (valid/ready) with start-of-frame
// and end-of-line markers. Patterns: 0 grid, 1 colour bars, 2 gradient,
// 3 checkerboard. en / pattern_sel only take effect at frame boundaries.
// Optional macro MIRE_SCROLL_EN: horizontal scroll by one pixel per frame.
module mire_gen #(
  parameter int HDISP = 640,
  parameter int VDISP = 480,
  parameter int GRID  = 16
) (
  input  logic        CLK,
  input  logic        NRST,
  input  logic        en,
  input  logic [1:0]  pattern_sel,
  input  logic        px_ready,
  output logic        px_valid,
  output logic [23:0] px_data,
  output logic        px_sof,
  output logic        px_eol
);
  localparam int            XW    = $clog2(HDISP);
  localparam int            YW    = $clog2(VDISP);
  localparam int            BARW  = HDISP / 8;
  localparam int            BW    = (BARW > 1) ? $clog2(BARW) : 1;
  localparam logic [XW-1:0] XMAX  = XW'(HDISP - 1);
  localparam logic [YW-1:0] YMAX  = YW'(VDISP - 1);
  localparam logic [BW-1:0] BMAX  = BW'(BARW - 1);
  localparam logic [31:0]   GMASK = 32'(GRID - 1);

  typedef enum logic [1:0] {S_IDLE, S_STREAM, S_PAUSE} state_t;

  state_t        r_state;
  logic [XW-1:0] r_x;      // raw column, drives eol/sof
  logic [YW-1:0] r_y;
  logic [XW-1:0] r_xp;     // pattern column (x plus scroll offset)
  logic [2:0]    r_bar;    // colour-bar index for r_xp
  logic [BW-1:0] r_bcnt;   // position inside the current bar
  logic [1:0]    r_pat;
  logic          r_valid;
  logic [23:0]   r_data;
  logic          r_sof;
  logic          r_eol;

  logic          w_xfer;
  logic          w_fend;
  logic [XW-1:0] w_off,      w_noff,      w_so_xp;
  logic [2:0]    w_off_bar,  w_noff_bar,  w_so_bar;
  logic [BW-1:0] w_off_bcnt, w_noff_bcnt, w_so_bcnt;
  logic [XW-1:0] w_nx, w_nxp;
  logic [YW-1:0] w_ny;
  logic [2:0]    w_nbar;
  logic [BW-1:0] w_nbcnt;
  logic [1:0]    w_npat;
  logic [23:0]   w_pix;
  logic          w_nsof;
  logic          w_neol;

  assign w_xfer = (r_state == S_STREAM) && px_ready;
  assign w_fend = w_xfer && (r_x == XMAX) && (r_y == YMAX);

`ifdef MIRE_SCROLL_EN
  logic [XW-1:0] r_off;
  logic [2:0]    r_off_bar;
  logic [BW-1:0] r_off_bcnt;

  // Offset steps one pixel per frame boundary, carrying its bar position
  always_ff @(posedge CLK or negedge NRST) begin
    if (!NRST) begin
      r_off      <= '0;
      r_off_bar  <= '0;
      r_off_bcnt <= '0;
    end else if (w_fend) begin
      r_off      <= w_noff;
      r_off_bar  <= w_noff_bar;
      r_off_bcnt <= w_noff_bcnt;
    end
  end

  assign w_off       = r_off;
  assign w_off_bar   = r_off_bar;
  assign w_off_bcnt  = r_off_bcnt;
  assign w_noff      = (r_off == XMAX) ? '0 : r_off + 1'b1;
  assign w_noff_bcnt = (r_off_bcnt == BMAX) ? '0 : r_off_bcnt + 1'b1;
  assign w_noff_bar  = (r_off_bcnt == BMAX) ? r_off_bar + 3'd1 : r_off_bar;
`else
  assign w_off       = '0;
  assign w_off_bar   = '0;
  assign w_off_bcnt  = '0;
  assign w_noff      = '0;
  assign w_noff_bar  = '0;
  assign w_noff_bcnt = '0;
`endif

  // A line start after the last pixel of a frame uses next frame's offset
  assign w_so_xp   = w_fend ? w_noff      : w_off;
  assign w_so_bar  = w_fend ? w_noff_bar  : w_off_bar;
  assign w_so_bcnt = w_fend ? w_noff_bcnt : w_off_bcnt;

  function automatic logic [23:0] f_pix(input logic [1:0]    pat,
                                        input logic [XW-1:0] xp,
                                        input logic [YW-1:0] y,
                                        input logic [2:0]    bar);
    logic [31:0] xe;
    logic [31:0] ye;
    logic [23:0] c;
    xe = 32'(xp);
    ye = 32'(y);
    c  = '0;
    case (pat)
      2'd0: c = (((xe & GMASK) == 0) || ((ye & GMASK) == 0)) ? 24'hFFFFFF : 24'h000000;
      2'd1: begin
        case (bar)
          3'd0: c = 24'hFFFFFF;
          3'd1: c = 24'hFFFF00;
          3'd2: c = 24'h00FFFF;
          3'd3: c = 24'h00FF00;
          3'd4: c = 24'hFF00FF;
          3'd5: c = 24'hFF0000;
          3'd6: c = 24'h0000FF;
          default: c = 24'h000000;
        endcase
      end
      2'd2: c = {xe[7:0], xe[7:0], xe[7:0]};
      default: c = (xe[5] ^ ye[5]) ? 24'hFFFFFF : 24'h000000;
    endcase
    return c;
  endfunction

  // Coordinates, bar position and pattern of the pixel to present next
  always_comb begin
    w_nx    = r_x;
    w_ny    = r_y;
    w_nxp   = r_xp;
    w_nbar  = r_bar;
    w_nbcnt = r_bcnt;
    w_npat  = r_pat;
    case (r_state)
      S_IDLE, S_PAUSE: begin
        w_nx    = '0;
        w_ny    = '0;
        w_nxp   = w_off;
        w_nbar  = w_off_bar;
        w_nbcnt = w_off_bcnt;
        w_npat  = pattern_sel;
      end
      S_STREAM: begin
        if (w_xfer) begin
          if (r_x == XMAX) begin
            w_nx    = '0;
            w_ny    = (r_y == YMAX) ? '0 : r_y + 1'b1;
            w_nxp   = w_so_xp;
            w_nbar  = w_so_bar;
            w_nbcnt = w_so_bcnt;
            if (w_fend) w_npat = pattern_sel;
          end else begin
            w_nx  = r_x + 1'b1;
            w_nxp = (r_xp == XMAX) ? '0 : r_xp + 1'b1;
            if (r_bcnt == BMAX) begin
              w_nbcnt = '0;
              w_nbar  = r_bar + 3'd1;
            end else begin
              w_nbcnt = r_bcnt + 1'b1;
            end
          end
        end
      end
      default: ;
    endcase
    w_pix  = f_pix(w_npat, w_nxp, w_ny, w_nbar);
    w_nsof = (w_nx == '0) && (w_ny == '0);
    w_neol = (w_nx == XMAX);
  end

  // Control FSM with registered pixel outputs
  always_ff @(posedge CLK or negedge NRST) begin
    if (!NRST) begin
      r_state <= S_IDLE;
      r_x     <= '0;
      r_y     <= '0;
      r_xp    <= '0;
      r_bar   <= '0;
      r_bcnt  <= '0;
      r_pat   <= '0;
      r_valid <= 1'b0;
      r_data  <= '0;
      r_sof   <= 1'b0;
      r_eol   <= 1'b0;
    end else begin
      r_x    <= w_nx;
      r_y    <= w_ny;
      r_xp   <= w_nxp;
      r_bar  <= w_nbar;
      r_bcnt <= w_nbcnt;
      r_pat  <= w_npat;
      case (r_state)
        S_IDLE, S_PAUSE: begin
          if (en) begin
            r_state <= S_STREAM;
            r_valid <= 1'b1;
            r_data  <= w_pix;
            r_sof   <= w_nsof;
            r_eol   <= w_neol;
          end else begin
            r_state <= S_PAUSE;
          end
        end
        S_STREAM: begin
          if (w_xfer) begin
            if (w_fend && !en) begin
              r_state <= S_PAUSE;
              r_valid <= 1'b0;
              r_sof   <= 1'b0;
              r_eol   <= 1'b0;
            end else begin
              r_data <= w_pix;
              r_sof  <= w_nsof;
              r_eol  <= w_neol;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign px_valid = r_valid;
  assign px_data  = r_data;
  assign px_sof   = r_sof;
  assign px_eol   = r_eol;

endmodule

// File: tb/tb_mire_gen.sv
// tb_mire_gen: directed bench for mire_gen on a reduced 64x40 raster.
// Frame sequence: bars, bars under random backpressure, grid with a
// mid-frame select change, checkerboard with en dropped mid-frame, pause
// pulse restart, and an asynchronous reset in the middle of a frame.
module tb_mire_gen;
  localparam int H = 64;
  localparam int V = 40;

  logic        CLK;
  logic        NRST;
  logic        en;
  logic [1:0]  pattern_sel;
  logic        px_ready;
  logic        px_valid;
  logic [23:0] px_data;
  logic        px_sof;
  logic        px_eol;

  int n_tests   = 0;
  int n_fail    = 0;
  int stall_err = 0;
  int to_cnt    = 0;

  logic [23:0] fb [V][H];

  mire_gen #(.HDISP(H), .VDISP(V), .GRID(16)) dut (
    .CLK        (CLK),
    .NRST       (NRST),
    .en         (en),
    .pattern_sel(pattern_sel),
    .px_ready   (px_ready),
    .px_valid   (px_valid),
    .px_data    (px_data),
    .px_sof     (px_sof),
    .px_eol     (px_eol)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Independent reference: bars computed by division here
  function automatic logic [23:0] ref_pix(input logic [1:0] p, input int x, input int y);
    int b;
    logic [7:0] g;
    case (p)
      2'd0: return ((x % 16 == 0) || (y % 16 == 0)) ? 24'hFFFFFF : 24'h000000;
      2'd1: begin
        b = x / (H / 8);
        case (b)
          0: return 24'hFFFFFF;
          1: return 24'hFFFF00;
          2: return 24'h00FFFF;
          3: return 24'h00FF00;
          4: return 24'hFF00FF;
          5: return 24'hFF0000;
          6: return 24'h0000FF;
          default: return 24'h000000;
        endcase
      end
      2'd2: begin
        g = x[7:0];
        return {g, g, g};
      end
      default: return (x[5] ^ y[5]) ? 24'hFFFFFF : 24'h000000;
    endcase
  endfunction

  // Called at a negedge; returns at the negedge after the next transfer.
  // Flags any change of data/markers while a pixel is stalled.
  task automatic get_px(input bit rnd, output logic [23:0] d, output logic s, output logic e);
    int          guard = 0;
    bit          done  = 0;
    bit          hv    = 0;
    logic [23:0] hd;
    logic        hs, he;
    d = 'x; s = 'x; e = 'x;
    while (!done) begin
      px_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (px_valid) begin
        if (hv && (px_data !== hd || px_sof !== hs || px_eol !== he)) stall_err++;
        hd = px_data; hs = px_sof; he = px_eol; hv = 1;
        if (px_ready) begin
          d = px_data; s = px_sof; e = px_eol;
          done = 1;
        end
      end
      @(negedge CLK);
      guard++;
      if (!done && guard > 1000) begin
        to_cnt++;
        done = 1;
      end
    end
  endtask

  // Consume npix pixels from (0,0) against the model; optionally change
  // pattern_sel/en right after pixel (cx,cy) is transferred.
  task automatic run_px(input string tag, input int npix, input bit rnd, input logic [1:0] pat,
                        input int cx, input int cy, input logic [1:0] csel, input logic cen);
    int          mism = 0;
    int          x = 0;
    int          y = 0;
    logic [23:0] d;
    logic        s, e;
    for (int i = 0; i < npix; i++) begin
      get_px(rnd, d, s, e);
      fb[y][x] = d;
      if (d !== ref_pix(pat, x, y) || s !== 1'(x == 0 && y == 0) || e !== 1'(x == H - 1)) mism++;
      if (x == cx && y == cy) begin
        pattern_sel = csel;
        en          = cen;
      end
      x++;
      if (x == H) begin
        x = 0;
        y++;
      end
    end
    chk({tag, "_seq_mismatches"}, mism, 0);
  endtask

  initial begin
    NRST = 1'b0; en = 1'b1; pattern_sel = 2'd1; px_ready = 1'b1;
    repeat (3) @(negedge CLK);
    chk("rst_valid", px_valid, 0);
    chk("rst_data",  px_data,  0);
    chk("rst_sof",   px_sof,   0);
    chk("rst_eol",   px_eol,   0);

    // release just after a rising edge: one idle cycle, then first pixel
    @(posedge CLK); #1 NRST = 1'b1;
    @(negedge CLK);
    chk("idle_valid", px_valid, 0);
    @(negedge CLK);
    chk("first_valid", px_valid, 1);
    chk("first_sof",   px_sof,   1);
    chk("first_data",  px_data,  24'hFFFFFF);

    // frame A: colour bars, full throughput
    run_px("A", H * V, 0, 2'd1, -1, -1, 2'd1, 1'b1);
    chk("A_x0",   fb[0][0],  24'hFFFFFF);
    chk("A_x8",   fb[0][8],  24'hFFFF00);
    chk("A_x16",  fb[0][16], 24'h00FFFF);
    chk("A_x47",  fb[5][47], 24'hFF0000);
    chk("A_x63",  fb[0][63], 24'h000000);
    chk("B_sof",  px_sof, 1);

    // frame B: bars under random backpressure; select grid for next frame
    run_px("B", H * V, 1, 2'd1, 5, 3, 2'd0, 1'b1);
    chk("B_stall_stable", stall_err, 0);
    chk("C_sof",  px_sof, 1);

    // frame C: grid; switching to checkerboard mid-frame must not show yet
    run_px("C", H * V, 0, 2'd0, 40, 20, 2'd3, 1'b1);
    chk("C_16_21", fb[21][16], 24'hFFFFFF);
    chk("C_17_21", fb[21][17], 24'h000000);
    chk("C_48_30", fb[30][48], 24'hFFFFFF);
    chk("C_5_32",  fb[32][5],  24'hFFFFFF);
    chk("D_sof",   px_sof, 1);

    // frame D: checkerboard; en dropped mid-frame, frame still completes
    run_px("D", H * V, 0, 2'd3, 10, 10, 2'd3, 1'b0);
    chk("D_0_0",   fb[0][0],   24'h000000);
    chk("D_32_0",  fb[0][32],  24'hFFFFFF);
    chk("D_32_32", fb[32][32], 24'h000000);
    chk("D_0_32",  fb[32][0],  24'hFFFFFF);
    chk("pause_valid0", px_valid, 0);
    @(negedge CLK);
    chk("pause_valid1", px_valid, 0);

    // one-cycle en pulse restarts at (0,0)
    en = 1'b1;
    @(negedge CLK);
    en = 1'b0;
    chk("resume_valid", px_valid, 1);
    chk("resume_sof",   px_sof,   1);
    chk("resume_data",  px_data,  24'h000000);

    // frame E partial, then async reset between edges at pixel (30,15)
    run_px("E", 15 * H + 30, 0, 2'd3, -1, -1, 2'd3, 1'b0);
    chk("pre_rst_valid", px_valid, 1);
    chk("pre_rst_sof",   px_sof,   0);
    en = 1'b1;
    #2 NRST = 1'b0;
    #1;
    chk("arst_valid", px_valid, 0);
    chk("arst_data",  px_data,  0);
    chk("arst_sof",   px_sof,   0);
    chk("arst_eol",   px_eol,   0);
    @(negedge CLK);
    NRST = 1'b1;
    @(negedge CLK);
    chk("restart_valid", px_valid, 1);
    chk("restart_sof",   px_sof,   1);
    chk("restart_data",  px_data,  24'h000000);

    // restarted frame continues correctly under backpressure
    run_px("F", 3 * H, 1, 2'd3, -1, -1, 2'd3, 1'b1);
    chk("F_32_1", fb[1][32], 24'hFFFFFF);
    chk("stall_stable", stall_err, 0);
    chk("timeouts",     to_cnt,    0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
